a5_keystream_ctrl: RTL

//  Sequencer for a full A5/1 burst. Takes a 64-bit Kc and 22-bit frame number and runs the whole run:
//  key load, frame load, 100 discard mixes, then 228 keystream bits over a valid/ready stream.

---
 rtl/a5_keystream_ctrl_pkg.sv | 24 ++
 rtl/a5_keystream_ctrl_if.sv | 25 ++
 rtl/a5_keystream_ctrl_step.sv | 29 ++
 rtl/a5_keystream_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/a5_keystream_ctrl_pkg.sv
// a5_keystream_ctrl_pkg: A5/1 register geometry, tap masks, clock bits, step counts and FSM encoding
package a5_keystream_ctrl_pkg;
   localparam int R1_W = 19;
   localparam int R2_W = 22;
   localparam int R3_W = 23;
   localparam int ST_W = 64;
   // Bit positions below are zero-based within each register (register bit [1] is index 0)
   localparam logic [R1_W-1:0] R1_TAPS = 19'h72000;
   localparam logic [R2_W-1:0] R2_TAPS = 22'h300000;
   localparam logic [R3_W-1:0] R3_TAPS = 23'h700080;
   localparam int R1_CLK = 8;
   localparam int R2_CLK = 10;
   localparam int R3_CLK = 10;
   localparam logic [7:0] KEY_BITS   = 8'd64;
   localparam logic [7:0] FRAME_BITS = 8'd22;
   localparam logic [7:0] MIX_STEPS  = 8'd100;
   localparam logic [7:0] KS_BITS    = 8'd228;
   localparam logic [7:0] LOAD_LAST  = KEY_BITS + FRAME_BITS - 8'd1;
   localparam logic [7:0] KS_LAST    = KS_BITS - 8'd1;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_RUN, S_DONE} fsm_e;
   function automatic logic maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/a5_keystream_ctrl_if.sv
// a5_keystream_ctrl_if: control + keystream stream bundle; master drives start/abort/key/frame/ready,
// slave (the controller) drives busy/ks_valid/ks_bit/done. auto_next_i exists only with A5_FRAME_AUTOINC_EN.
interface a5_keystream_ctrl_if;
   logic        start_i;
   logic        abort_i;
   logic [63:0] key_i;
   logic [21:0] frame_i;
   logic        ks_ready_i;
   logic        busy_o;
   logic        ks_valid_o;
   logic        ks_bit_o;
   logic        done_o;
`ifdef A5_FRAME_AUTOINC_EN
   logic        auto_next_i;
   modport master(output start_i, abort_i, key_i, frame_i, ks_ready_i, auto_next_i,
                  input busy_o, ks_valid_o, ks_bit_o, done_o);
   modport slave(input start_i, abort_i, key_i, frame_i, ks_ready_i, auto_next_i,
                 output busy_o, ks_valid_o, ks_bit_o, done_o);
`else
   modport master(output start_i, abort_i, key_i, frame_i, ks_ready_i,
                  input busy_o, ks_valid_o, ks_bit_o, done_o);
   modport slave(input start_i, abort_i, key_i, frame_i, ks_ready_i,
                 output busy_o, ks_valid_o, ks_bit_o, done_o);
`endif
endinterface

// File: rtl/a5_keystream_ctrl_step.sv
// a5_keystream_ctrl_step: one combinational A5/1 step of {R3,R2,R1}
//  state_i      current 64-bit state
//  inj_i        bit XORed into every feedback bit (0 outside key/frame load)
//  force_all_i  step all registers regardless of majority
//  next_state_o state after the step
module a5_keystream_ctrl_step
   import a5_keystream_ctrl_pkg::*;
(
   input  logic [ST_W-1:0] state_i,
   input  logic            inj_i,
   input  logic            force_all_i,
   output logic [ST_W-1:0] next_state_o
);
   logic [R1_W-1:0] r1;
   logic [R2_W-1:0] r2;
   logic [R3_W-1:0] r3;
   logic m, fb1, fb2, fb3, c1, c2, c3;
   assign {r3, r2, r1} = state_i;
   assign m   = maj(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);
   assign fb1 = ^(r1 & R1_TAPS) ^ inj_i;
   assign fb2 = ^(r2 & R2_TAPS) ^ inj_i;
   assign fb3 = ^(r3 & R3_TAPS) ^ inj_i;
   assign c1  = force_all_i | (r1[R1_CLK] == m);
   assign c2  = force_all_i | (r2[R2_CLK] == m);
   assign c3  = force_all_i | (r3[R3_CLK] == m);
   assign next_state_o = {c3 ? {r3[R3_W-2:0], fb3} : r3,
                          c2 ? {r2[R2_W-2:0], fb2} : r2,
                          c1 ? {r1[R1_W-2:0], fb1} : r1};
endmodule

// File: rtl/a5_keystream_ctrl.sv
// a5_keystream_ctrl: A5/1 burst sequencer (key load, frame load, 100 discard mixes, 228 keystream bits)
//  clk    clock, posedge
//  rst_n  asynchronous active-low reset
//  bus    slave side of a5_keystream_ctrl_if (start/abort/key/frame/ks_ready in; busy/ks_valid/ks_bit/done out)
//  A5_FRAME_AUTOINC_EN: when defined, auto_next_i in DONE reloads with frame+1 instead of returning to IDLE.
module a5_keystream_ctrl
   import a5_keystream_ctrl_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   a5_keystream_ctrl_if.slave bus
);
   fsm_e            fsm_q;
   logic [7:0]      cnt_q;
   logic [ST_W-1:0] st_q, st_d;
   logic [63:0]     key_q;
   logic [21:0]     frame_q;
   logic [4:0]      fidx;
   logic            busy_q, ks_valid_q, done_q, load, inj;
   assign load = fsm_q == S_LOAD;
   assign fidx = 5'(cnt_q - KEY_BITS);
   assign inj  = load & (cnt_q < KEY_BITS ? key_q[cnt_q[5:0]] : frame_q[fidx]);
   a5_keystream_ctrl_step u_step (
      .state_i     (st_q),
      .inj_i       (inj),
      .force_all_i (load),
      .next_state_o(st_d)
   );
   assign bus.busy_o     = busy_q;
   assign bus.ks_valid_o = ks_valid_q;
   assign bus.done_o     = done_q;
   assign bus.ks_bit_o   = st_q[R1_W-1] ^ st_q[R1_W+R2_W-1] ^ st_q[ST_W-1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fsm_q      <= S_IDLE;
         cnt_q      <= '0;
         st_q       <= '0;
         key_q      <= '0;
         frame_q    <= '0;
         busy_q     <= 1'b0;
         ks_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else if (bus.abort_i) begin
         // abort beats start in IDLE and a same-cycle handshake in RUN
         fsm_q      <= S_IDLE;
         busy_q     <= 1'b0;
         ks_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else
         case (fsm_q)
            S_IDLE:
               if (bus.start_i) begin
                  fsm_q   <= S_LOAD;
                  key_q   <= bus.key_i;
                  frame_q <= bus.frame_i;
                  st_q    <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            S_LOAD: begin
               st_q  <= st_d;
               cnt_q <= cnt_q == LOAD_LAST ? 8'd0 : cnt_q + 8'd1;
               if (cnt_q == LOAD_LAST) fsm_q <= S_MIX;
            end
            S_MIX: begin
               // MIX_STEPS discards plus one more step that yields keystream bit 0
               st_q  <= st_d;
               cnt_q <= cnt_q == MIX_STEPS ? 8'd0 : cnt_q + 8'd1;
               if (cnt_q == MIX_STEPS) begin
                  fsm_q      <= S_RUN;
                  ks_valid_q <= 1'b1;
               end
            end
            S_RUN:
               if (bus.ks_ready_i) begin
                  if (cnt_q == KS_LAST) begin
                     fsm_q      <= S_DONE;
                     ks_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                     st_q  <= st_d;
                  end
               end
            S_DONE: begin
               done_q <= 1'b0;
`ifdef A5_FRAME_AUTOINC_EN
               if (bus.auto_next_i) begin
                  fsm_q   <= S_LOAD;
                  frame_q <= frame_q + 22'd1;
                  st_q    <= '0;
                  cnt_q   <= '0;
               end else begin
                  fsm_q  <= S_IDLE;
                  busy_q <= 1'b0;
               end
`else
               fsm_q  <= S_IDLE;
               busy_q <= 1'b0;
`endif
            end
            default: fsm_q <= S_IDLE;
         endcase
endmodule
